c17_response_compactor: RTL and testbench
=========================================

Name: c17_response_compactor

Overview:
- Downstream response-compaction stage for the c17 ISCAS benchmark datapath in the bit-level pipelining work.
- Accepts the 2-bit output vector {N23,N22} from the pipelined c17 stage over a valid/ready handshake.
- Compacts NUM_PATTERNS samples into a multiple-input signature register (MISR), then compares the result against a golden signature and reports pass or fail.
- Provides self-checking BIST-style closure for the c17 pipeline without a per-vector scoreboard.

Parameters:
- SIG_W, 16, MISR width in bits (>=4).
- POLY, 16'h1021, feedback polynomial taps (x^16+x^12+x^5+1), SIG_W bits wide.
- SEED, 16'h0000, MISR value loaded on start.
- NUM_PATTERNS, 32, number of samples compacted per run (>=1; 32 = exhaustive c17 input space).
- CNT_W, 8, pattern counter width; must satisfy 2^CNT_W > NUM_PATTERNS.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; honoured in IDLE only.
- abort  input  1  return to IDLE from any state; done is not asserted.
- golden_sig  input  SIG_W  expected signature, sampled on the accepted start.
- in_valid  input  1  upstream sample valid.
- in_data  input  2  {N23,N22} from the c17 stage.
- in_ready  output  1  high only in RUN.
- busy  output  1  high in RUN and CHECK.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  signature matched; held until the next accepted start.
- fail  output  1  signature mismatched; held until the next accepted start.
- signature  output  SIG_W  current MISR contents.
- pattern_count  output  CNT_W  number of samples accepted in the current run.

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, MISR=SEED, golden register=0, pattern_count=0, in_ready=0, busy=0, done=0, pass=0, fail=0.
- FSM has three states: IDLE, RUN, CHECK. All outputs are registered or decoded from state.
- IDLE:
  - start=1 -> load MISR<=SEED, pattern_count<=0, latch golden_sig, clear pass/fail, go to RUN.
  - in_valid is ignored.
- RUN:
  - in_ready=1. A transfer occurs when in_valid&in_ready.
  - On a transfer: MISR <= {MISR[SIG_W-2:0],1'b0} ^ (MISR[SIG_W-1] ? POLY : 0) ^ {{SIG_W-2{1'b0}}, in_data}; pattern_count increments.
  - The transfer that makes pattern_count reach NUM_PATTERNS also moves the FSM to CHECK.
  - Cycles without in_valid leave MISR and count unchanged (bubbles allowed; no timeout).
  - start in RUN is ignored.
- CHECK (exactly one cycle):
  - in_ready=0.
  - At the clock edge: pass<=(MISR==golden), fail<=(MISR!=golden), done<=1, go to IDLE.
  - done is high for exactly the one cycle after CHECK.
- Latency: last transfer at edge k -> CHECK during cycle k..k+1 -> done/pass/fail visible after edge k+1.
- pass and fail are mutually exclusive. Both are 0 from reset and from start until the run completes.
- start in the same cycle as done (state IDLE) is accepted: pass/fail clear on that edge, and done still falls.
- abort has priority over start, transfers and CHECK:
  - next state IDLE; MISR and count frozen; pass/fail cleared; no done.
- Asynchronous reset mid-run returns all state to reset values immediately; a partial run is discarded.
- pattern_count never exceeds NUM_PATTERNS; no wrap within a run.
- signature is stable and readable after done until the next start.

Test Plan:
- Reset: assert rst_n=0 mid-RUN with in_valid=1 -> in_ready, busy, done, pass, fail all 0 immediately; signature=SEED.
- Basic pass (NUM_PATTERNS=4, SEED=0, golden=16'h0011): 4 transfers of 2'b11 -> MISR 0003, 0005, 0009, 0011; done pulses 1 cycle; pass=1, fail=0; pattern_count=4.
- Mismatch: same stimulus with golden=16'h0012 -> done pulse, fail=1, pass=0; signature=16'h0011.
- Feedback tap (SEED=16'h8000, NUM_PATTERNS=1): one transfer of 2'b00 -> signature=16'h1021, done after 2 edges.
- Handshake (NUM_PATTERNS=4): in_valid toggled with gaps, plus in_valid asserted during IDLE and CHECK -> only RUN transfers counted; result identical to the basic pass case.
- Abort/restart: abort after 2 transfers -> IDLE, no done, pass/fail=0. Then start plus 4 transfers of 2'b11 -> pass. Also start asserted during RUN -> ignored, count continues.

Source files
------------

// File: rtl/c17_response_compactor.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | c17_response_compactor: MISR compaction of c17 outputs with golden compare.
// | Rev 1.0
// +-----------------------------------------------------------------------------
module c17_response_compactor #(
  parameter int unsigned       SIG_W        = 16,
  parameter logic [SIG_W-1:0]  POLY         = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED         = 16'h0000,
  parameter int unsigned       NUM_PATTERNS = 32,
  parameter int unsigned       CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             in_valid,
  input  logic [1:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pattern_count
);

  localparam logic [1:0]       c_IDLE  = 2'd0;
  localparam logic [1:0]       c_RUN   = 2'd1;
  localparam logic [1:0]       c_CHECK = 2'd2;
  localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(NUM_PATTERNS - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [SIG_W-1:0] r_misr;
  logic [SIG_W-1:0] r_golden;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic [SIG_W-1:0] w_misr_next;
  logic             w_xfer;

  assign w_xfer      = (r_state == c_RUN) && in_valid;
  assign w_misr_next = {r_misr[SIG_W-2:0], 1'b0}
                     ^ (r_misr[SIG_W-1] ? POLY : '0)
                     ^ {{(SIG_W-2){1'b0}}, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (start) w_state_next = c_RUN;
        c_RUN:   if (w_xfer && (r_count == c_LAST)) w_state_next = c_CHECK;
        c_CHECK: w_state_next = c_IDLE;
        default: w_state_next = c_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      c_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      c_CHECK: busy = 1'b1;
      default: ;
    endcase
  end

  // Datapath: abort freezes MISR and count but still clears the verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misr   <= SEED;
      r_golden <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_pass <= 1'b0;
        r_fail <= 1'b0;
      end else begin
        case (r_state)
          c_IDLE: if (start) begin
            r_misr   <= SEED;
            r_count  <= '0;
            r_golden <= golden_sig;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
          end
          c_RUN: if (w_xfer) begin
            r_misr  <= w_misr_next;
            r_count <= r_count + 1'b1;
          end
          c_CHECK: begin
            r_pass <= (r_misr == r_golden);
            r_fail <= (r_misr != r_golden);
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign done          = r_done;
  assign pass          = r_pass;
  assign fail          = r_fail;
  assign signature     = r_misr;
  assign pattern_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_c17_response_compactor.sv
`default_nettype none
// Bench: random and directed runs against a polynomial-arithmetic signature model.
module tb_c17_response_compactor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4-pattern runs from a zero seed.
  logic        a_start = 0, a_abort = 0, a_valid = 0;
  logic [15:0] a_golden = 0;
  logic [1:0]  a_data = 0;
  logic        a_ready, a_busy, a_done, a_pass, a_fail;
  logic [15:0] a_sig;
  logic [7:0]  a_cnt;

  // Instance B: single-pattern run from a seed with the top bit set.
  logic        b_start = 0, b_abort = 0, b_valid = 0;
  logic [15:0] b_golden = 0;
  logic [1:0]  b_data = 0;
  logic        b_ready, b_busy, b_done, b_pass, b_fail;
  logic [15:0] b_sig;
  logic [7:0]  b_cnt;

  c17_response_compactor #(.SIG_W(16), .POLY(16'h1021), .SEED(16'h0000),
                           .NUM_PATTERNS(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .golden_sig(a_golden), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail(a_fail), .signature(a_sig), .pattern_count(a_cnt));

  c17_response_compactor #(.SIG_W(16), .POLY(16'h1021), .SEED(16'h8000),
                           .NUM_PATTERNS(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .golden_sig(b_golden), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail(b_fail), .signature(b_sig), .pattern_count(b_cnt));

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signature as a polynomial over GF(2): multiply by x, reduce mod x^16+x^12+x^5+1, add sample.
  function automatic logic [15:0] step(input logic [15:0] s_in, input logic [1:0] d);
    int s;
    s = int'(s_in) * 2;
    if (s >= 65536) s = (s - 65536) ^ 'h1021;
    s = s ^ int'(d);
    return s[15:0];
  endfunction

  function automatic logic [15:0] sig_of(input logic [1:0] smp [4]);
    logic [15:0] s = 16'h0000;
    for (int i = 0; i < 4; i++) s = step(s, smp[i]);
    return s;
  endfunction

  // Entered at a negedge; returns at the negedge where done should be high.
  task automatic run_a(input logic [1:0] smp [4], input logic [15:0] golden,
                       input int max_gap, input string tag);
    logic [15:0] exp_sig = 16'h0000;
    a_start  = 1;
    a_golden = golden;
    a_valid  = 1'($urandom_range(0, 1));
    a_data   = 2'($urandom);
    @(negedge clk);
    a_start = 0;
    chk({tag, "_start_busy"}, a_busy, 1);
    chk({tag, "_start_ready"}, a_ready, 1);
    chk({tag, "_start_cnt"}, a_cnt, 0);
    chk({tag, "_start_sig"}, a_sig, 16'h0000);
    chk({tag, "_start_verdict"}, {a_done, a_pass, a_fail}, 0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        a_valid = 0;
        a_data  = 2'($urandom);
        a_start = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk({tag, "_bubble_cnt"}, a_cnt, i);
        chk({tag, "_bubble_sig"}, a_sig, exp_sig);
      end
      a_valid = 1;
      a_data  = smp[i];
      a_start = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      exp_sig = step(exp_sig, smp[i]);
      chk({tag, "_xfer_sig"}, a_sig, exp_sig);
      chk({tag, "_xfer_cnt"}, a_cnt, i + 1);
    end
    // CHECK cycle: samples offered here must be ignored.
    a_start = 0;
    a_valid = 1;
    a_data  = 2'($urandom);
    chk({tag, "_check_state"}, {a_ready, a_busy, a_done}, 3'b010);
    @(negedge clk);
    a_valid = 0;
    chk({tag, "_done"}, {a_done, a_busy, a_ready}, 3'b100);
    chk({tag, "_pass"}, a_pass, exp_sig == golden);
    chk({tag, "_fail"}, a_fail, exp_sig != golden);
    chk({tag, "_end_sig"}, a_sig, exp_sig);
    chk({tag, "_end_cnt"}, a_cnt, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  smp [4];
    logic [15:0] g;
    logic        keep_p, keep_f;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_flags", {a_ready, a_busy, a_done, a_pass, a_fail}, 0);
    chk("rst_a_sig", a_sig, 16'h0000);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_sig", b_sig, 16'h8000);
    rst_n = 1;
    @(negedge clk);
    chk("idle_a_flags", {a_ready, a_busy, a_done}, 0);

    // Basic pass: 4 x 2'b11 -> 0x0011
    smp = '{2'b11, 2'b11, 2'b11, 2'b11};
    chk("model_basic", sig_of(smp), 16'h0011);
    run_a(smp, 16'h0011, 0, "basic");
    @(negedge clk);
    chk("basic_done_fall", a_done, 0);
    chk("basic_hold", {a_pass, a_fail, a_sig}, {2'b10, 16'h0011});

    // Mismatch: same data, wrong golden; also gapped handshake
    run_a(smp, 16'h0012, 3, "mismatch");
    // Back-to-back start on the done cycle
    run_a(smp, 16'h0011, 2, "b2b");

    // Random runs, golden either correct or with one flipped bit
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) smp[i] = 2'($urandom);
      g = sig_of(smp);
      if ($urandom_range(0, 1) == 1) g = g ^ (16'h1 << $urandom_range(0, 15));
      run_a(smp, g, 3, "rand");
    end
    @(negedge clk);
    keep_p = a_pass;
    keep_f = a_fail;
    repeat (2) @(negedge clk);
    chk("verdict_held", {a_pass, a_fail, a_done}, {keep_p, keep_f, 1'b0});

    // Abort after two transfers
    a_start = 1; a_golden = 16'h0011;
    @(negedge clk);
    a_start = 0; a_valid = 1; a_data = 2'b11;
    repeat (2) @(negedge clk);
    a_valid = 0; a_abort = 1;
    @(negedge clk);
    a_abort = 0;
    chk("abort_state", {a_ready, a_busy, a_done, a_pass, a_fail}, 0);
    chk("abort_cnt", a_cnt, 2);
    chk("abort_sig", a_sig, 16'h0005);
    a_valid = 1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", {a_done, a_busy, a_cnt}, {2'b00, 8'd2});
    end
    a_valid = 0;
    smp = '{2'b11, 2'b11, 2'b11, 2'b11};
    run_a(smp, 16'h0011, 1, "restart");

    // Asynchronous reset mid-run
    @(negedge clk);
    a_start = 1; a_golden = 16'h0011;
    @(negedge clk);
    a_start = 0; a_valid = 1; a_data = 2'b11;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_flags", {a_ready, a_busy, a_done, a_pass, a_fail}, 0);
    chk("async_rst_sig", a_sig, 16'h0000);
    chk("async_rst_cnt", a_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    a_valid = 0;
    @(negedge clk);
    chk("post_rst_idle", {a_busy, a_cnt}, 0);

    // Feedback tap: seed 0x8000, one 2'b00 sample -> 0x1021
    b_start = 1; b_golden = 16'h1021;
    @(negedge clk);
    b_start = 0; b_valid = 1; b_data = 2'b00;
    @(negedge clk);
    b_valid = 0;
    chk("tap_sig", b_sig, 16'h1021);
    chk("tap_check", {b_ready, b_busy, b_done, b_cnt}, {3'b010, 8'd1});
    @(negedge clk);
    chk("tap_done", {b_done, b_pass, b_fail}, 3'b110);
    @(negedge clk);
    chk("tap_done_fall", b_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
